// File: rtl/pid_pkg.sv
// Shared constants, FSM state type and saturation helper for the PID channel scheduler.
package pid_pkg;

  localparam int unsigned FRAC    = 10;          // Q10 gain fraction bits
  localparam int unsigned ERR_W   = 16;          // error / state register width
  localparam int unsigned ACC_W   = 34;          // accumulator width
  localparam int unsigned INT_MAX = 32767;       // integral upper clamp
  localparam int unsigned MUL_AW  = ERR_W + 1;   // I and D need 17 bits
  localparam int unsigned PROD_W  = MUL_AW + ERR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC_P = 3'd1,
    MAC_I = 3'd2,
    MAC_D = 3'd3,
    OUT   = 3'd4
  } pid_sched_st_t;

  // Clamp a 17-bit integral term to 0..INT_MAX (INT_MAX is 2^15-1).
  function automatic logic [ERR_W-1:0] sat_int(input logic [MUL_AW-1:0] v);
    if (v[MUL_AW-1])
      return '0;
    else if (v[MUL_AW-2])
      return ERR_W'(INT_MAX);
    else
      return {1'b0, v[ERR_W-2:0]};
  endfunction

endpackage

// File: rtl/pid_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req (requests), ptr (last winner) -> grant (one-hot), idx (winner index),
//        found (any request present). Search starts at ptr+1 and wraps.
module pid_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int unsigned cand;
    logic [IW-1:0] cidx;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(ptr) + i) % N;
      cidx = IW'(cand);
      if (!found && req[cidx]) begin
        found       = 1'b1;
        grant[cidx] = 1'b1;
        idx         = cidx;
      end
    end
  end

endmodule

// File: rtl/pid_chan_sched.sv
// Time-multiplexed PID engine: one multiplier and accumulator shared by N_CH loops.
// Ports: clk/reset (async, active-high); req_valid/req_refer/req_data/req_ready
// per-channel sample ports (refer/data packed 8 bits per channel); ch_clear zeroes a
// channel's stored state; out_valid/out_ready/out_ch/out_control result port; busy.
module pid_chan_sched
  import pid_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  parameter real         K_P  = 0.9,
  parameter real         K_I  = 0.9,
  parameter real         K_D  = 0.9,
  parameter int unsigned CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   req_valid,
  input  logic [N_CH*8-1:0] req_refer,
  input  logic [N_CH*8-1:0] req_data,
  output logic [N_CH-1:0]   req_ready,
  input  logic [N_CH-1:0]   ch_clear,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     out_ch,
  output logic [15:0]       out_control,
  output logic              busy
);

  localparam int B0 = int'(K_P * real'(1 << FRAC));
  localparam int B1 = int'(K_I * real'(1 << FRAC));
  localparam int B2 = int'(K_D * real'(1 << FRAC));
  localparam logic signed [ERR_W-1:0] C0 = ERR_W'(B0);
  localparam logic signed [ERR_W-1:0] C1 = ERR_W'(B1);
  localparam logic signed [ERR_W-1:0] C2 = ERR_W'(B2);

  pid_sched_st_t state, state_next;

  logic [N_CH-1:0]          grant;
  logic [CW-1:0]            g_idx, ptr, ch_q;
  logic                     g_found, hs;
  logic [7:0]               refer_sel, data_sel;
  logic signed [ERR_W-1:0]  e_new, e_q;
  logic [ERR_W-1:0]         err_snap, int_snap;
  logic signed [MUL_AW-1:0] i_val, d_val, mul_a;
  logic signed [ERR_W-1:0]  mul_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic                     wb_kill;
  logic [ERR_W-1:0]         err_q [N_CH];
  logic [ERR_W-1:0]         int_q [N_CH];

  pid_rr_arbiter #(.N(N_CH), .IW(CW)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (g_idx),
    .found (g_found)
  );

  // Grant is only offered in IDLE; handshake is implied by the grant itself.
  assign req_ready = (state == IDLE && !reset) ? grant : '0;
  assign hs        = (state == IDLE) && g_found;

  // Select the winner's setpoint / measurement.
  always_comb begin
    refer_sel = '0;
    data_sel  = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (g_idx == CW'(c)) begin
        refer_sel = req_refer[c*8 +: 8];
        data_sel  = req_data[c*8 +: 8];
      end
    end
  end

  assign e_new = {{(ERR_W-8){refer_sel[7]}}, refer_sel} - {{(ERR_W-8){data_sel[7]}}, data_sel};

  // Integral and derivative terms use the state snapshot taken at grant time.
  assign i_val = {e_q[ERR_W-1], e_q} + {int_snap[ERR_W-1], int_snap};
  assign d_val = {e_q[ERR_W-1], e_q} - {err_snap[ERR_W-1], err_snap};

  // Shared multiplier operand steering.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MAC_P:   begin mul_a = {e_q[ERR_W-1], e_q}; mul_b = C0; end
      MAC_I:   begin mul_a = i_val;               mul_b = C1; end
      MAC_D:   begin mul_a = d_val;               mul_b = C2; end
      default: begin mul_a = '0;                  mul_b = '0; end
    endcase
  end

  assign prod     = mul_a * mul_b;
  assign acc_next = acc + ACC_W'(prod);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hs) state_next = MAC_P;
      MAC_P:   state_next = MAC_I;
      MAC_I:   state_next = MAC_D;
      MAC_D:   state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on grant, accumulate in MAC states, track writeback suppression.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= CW'(N_CH - 1);
      ch_q     <= '0;
      e_q      <= '0;
      err_snap <= '0;
      int_snap <= '0;
      acc      <= '0;
      wb_kill  <= 1'b0;
    end else begin
      if (hs) begin
        ptr      <= g_idx;
        ch_q     <= g_idx;
        e_q      <= e_new;
        err_snap <= err_q[g_idx];
        int_snap <= int_q[g_idx];
        acc      <= '0;
        wb_kill  <= 1'b0;
      end else if (state == MAC_P || state == MAC_I || state == MAC_D) begin
        acc <= acc_next;
      end
      // A clear seen while this channel is in flight cancels the later writeback.
      if ((state == MAC_P || state == MAC_I) && ch_clear[ch_q])
        wb_kill <= 1'b1;
    end
  end

  // Per-channel state; clear has priority over writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        err_q[c] <= '0;
        int_q[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (ch_clear[c]) begin
          err_q[c] <= '0;
          int_q[c] <= '0;
        end else if (state == MAC_D && !wb_kill && ch_q == CW'(c)) begin
          err_q[c] <= e_q;
          int_q[c] <= sat_int(i_val);
        end
      end
    end
  end

  // Result port, held until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_ch      <= '0;
      out_control <= '0;
      busy        <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      if (state == MAC_D) begin
        out_valid   <= 1'b1;
        out_ch      <= ch_q;
        out_control <= acc_next[FRAC +: 16];
      end else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pid_chan_sched.sv
// Directed self-checking bench for pid_chan_sched (N_CH=4, default Q10 gains = 922).
module tb_pid_chan_sched;

  localparam int N_CH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N_CH-1:0]   req_valid = '0;
  logic [N_CH*8-1:0] req_refer = '0;
  logic [N_CH*8-1:0] req_data = '0;
  logic [N_CH-1:0]   req_ready;
  logic [N_CH-1:0]   ch_clear = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [1:0]        out_ch;
  logic [15:0]       out_control;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;

  pid_chan_sched #(.N_CH(N_CH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_refer   (req_refer),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .ch_clear    (ch_clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ch      (out_ch),
    .out_control (out_control),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Present one sample, wait for grant, then check latency, channel and control value.
  task automatic send(input int ch, input int refer, input int data, input int exp_ctl,
                      input string tag);
    int wt;
    int lat;
    req_refer[ch*8 +: 8] = 8'(refer);
    req_data[ch*8 +: 8]  = 8'(data);
    req_valid[ch]        = 1'b1;
    #1;
    wt = 0;
    while (!req_ready[ch] && wt < 50) begin
      tick();
      wt++;
    end
    if (!req_ready[ch]) begin
      check({tag, "_grant_timeout"}, 0, 1);
      req_valid[ch] = 1'b0;
      return;
    end
    tick();
    req_valid[ch] = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, 4);
    check({tag, "_ch"}, int'(out_ch), ch);
    check({tag, "_ctl"}, int'($signed(out_control)), exp_ctl);
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    int ng;
    int bad;
    int idx;
    int wt;

    // Reset state, with all requests pending.
    req_valid = '1;
    tick();
    check("rst_ready", int'(req_ready), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_ch", int'(out_ch), 0);
    check("rst_ctl", int'(out_control), 0);
    check("rst_busy", int'(busy), 0);
    req_valid = '0;
    do_reset();

    // Ch0 fresh and repeated: 30*922>>10=27, 30*922>>10=27, 40*922>>10=36.
    send(0, 10, 0, 27, "t1");
    check("t1_err0", int'($signed(dut.err_q[0])), 10);
    check("t1_int0", int'(dut.int_q[0]), 10);
    send(0, 10, 0, 27, "t2a");
    check("t2a_int0", int'(dut.int_q[0]), 20);
    send(0, 10, 0, 36, "t2b");
    check("t2b_int0", int'(dut.int_q[0]), 30);

    // Ch1 negative error: -60*922>>10 = floor(-54.02) = -55; integral clamps to 0.
    send(1, 0, 20, -55, "t3");
    check("t3_int1", int'(dut.int_q[1]), 0);
    check("t3_err1", int'($signed(dut.err_q[1])), -20);

    // All four channels valid: strict rotation from channel 0 after reset.
    do_reset();
    req_refer = '0;
    req_data  = '0;
    req_valid = '1;
    #1;
    ng  = 0;
    bad = 0;
    for (int cyc = 0; cyc < 200 && ng < 5; cyc++) begin
      if (busy && req_ready != '0) bad++;
      if (req_ready != '0) begin
        check($sformatf("t4_onehot_%0d", ng), int'($onehot(req_ready)), 1);
        idx = -1;
        for (int b = 0; b < N_CH; b++) if (req_ready[b]) idx = b;
        check($sformatf("t4_grant_%0d", ng), idx, ng % N_CH);
        ng++;
      end
      tick();
    end
    req_valid = '0;
    check("t4_grants_seen", ng, 5);
    check("t4_no_grant_busy", bad, 0);
    wt = 0;
    while (busy && wt < 20) begin
      tick();
      wt++;
    end
    check("t4_drained", int'(busy), 0);

    // Back-pressure in OUT: result and ready held for 10 clocks.
    req_refer[3*8 +: 8] = 8'd10;
    req_data[3*8 +: 8]  = 8'd0;
    req_valid[3] = 1'b1;
    #1;
    wt = 0;
    while (!req_ready[3] && wt < 50) begin
      tick();
      wt++;
    end
    tick();
    req_valid[3] = 1'b0;
    out_ready    = 1'b0;
    wt = 0;
    while (!out_valid && wt < 20) begin
      tick();
      wt++;
    end
    check("t5_ctl", int'($signed(out_control)), 27);
    req_refer[7:0] = 8'd0;
    req_data[7:0]  = 8'd0;
    req_valid[0]   = 1'b1;
    #1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_control !== 16'd27 || req_ready !== '0)
        bad++;
      tick();
    end
    check("t5_stall_stable", bad, 0);
    out_ready = 1'b1;
    tick();
    check("t5_grant_after_release", int'(req_ready), 1);
    tick();
    req_valid[0] = 1'b0;
    wt = 0;
    while (!out_valid && wt < 20) begin
      tick();
      wt++;
    end
    check("t5_next_ch", int'(out_ch), 0);
    check("t5_next_ctl", int'($signed(out_control)), 0);
    tick();

    // Clear ch2 during MAC_I of its own sample: result from old state, writeback dropped.
    req_refer[2*8 +: 8] = 8'd0;
    req_data[2*8 +: 8]  = 8'd20;
    req_valid[2] = 1'b1;
    #1;
    wt = 0;
    while (!req_ready[2] && wt < 50) begin
      tick();
      wt++;
    end
    tick();                 // handshake -> MAC_P
    req_valid[2] = 1'b0;
    tick();                 // -> MAC_I
    ch_clear[2] = 1'b1;
    tick();                 // clear edge -> MAC_D
    ch_clear[2] = 1'b0;
    tick();                 // -> OUT
    check("t6_valid", int'(out_valid), 1);
    check("t6_ctl", int'($signed(out_control)), -55);
    check("t6_err2", int'($signed(dut.err_q[2])), 0);
    tick();
    // Fresh: 27; a leaked writeback (err=-20,int=0) would give 50*922>>10 = 45.
    send(2, 10, 0, 27, "t6_fresh");
    send(2, 10, 0, 27, "t6_second");   // leaves err=10, int=20

    // Async reset during MAC_I aborts the sample.
    req_refer[2*8 +: 8] = 8'd10;
    req_data[2*8 +: 8]  = 8'd0;
    req_valid[2] = 1'b1;
    #1;
    wt = 0;
    while (!req_ready[2] && wt < 50) begin
      tick();
      wt++;
    end
    tick();
    req_valid[2] = 1'b0;
    tick();                 // MAC_I
    reset = 1'b1;
    #2;
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) bad++;
    end
    check("t6_reset_no_result", bad, 0);
    // Fresh: 27; surviving state (err=10,int=20) would give 40*922>>10 = 36.
    send(2, 10, 0, 27, "t6_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
